// File: rtl/srio_dma_split.sv
// srio_dma_split: cuts one continuous 64-bit DMA stream into fixed-size SRIO
// SWRITE packets. Each packet is a single header beat followed by up to
// `beats` payload beats. Payload beats pass straight through, with no latency.
//
// Ports:
//   AXIS_ACLK, AXIS_ARESET   clock and synchronous active-high reset
//   S_AXIS_*                 DMA payload stream in (TDATA/TVALID/TLAST/TREADY)
//   M_AXIS_*                 SRIO transmit stream out (TDATA/TVALID/TLAST/TUSER/TREADY)
//   cmd                      [0] enable, [1] clear counters (level), [31:16] dest_id
//   num_pkts                 [5:0] payload beats per packet (0 means 32)
//   src_id                   local device ID, driven on TUSER[31:16]
//   base_addr                target address of the first packet of a transfer
//   status                   [15:0] pkt_cnt, [16] short_err, [17] busy
module srio_dma_split #(
  parameter int unsigned ADDR_W = 34
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESET,
  input  logic [63:0]       S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  input  logic              S_AXIS_TLAST,
  output logic              S_AXIS_TREADY,
  output logic [63:0]       M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  output logic              M_AXIS_TLAST,
  output logic [31:0]       M_AXIS_TUSER,
  input  logic              M_AXIS_TREADY,
  input  logic [31:0]       cmd,
  input  logic [31:0]       num_pkts,
  input  logic [15:0]       src_id,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [31:0]       status
);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e            state;
  logic [5:0]        beats;
  logic [5:0]        beat_cnt;
  logic [7:0]        tid;
  logic [15:0]       pkt_cnt;
  logic [ADDR_W-1:0] addr_off;
  logic              short_err;
  logic [63:0]       hdr;
  logic [31:0]       tuser;

  logic [5:0]        beats_cfg;
  logic [7:0]        size_cfg;
  logic [7:0]        tid_eff;
  logic [ADDR_W-1:0] off_eff;
  logic [ADDR_W-1:0] hdr_addr;
  logic [33:0]       addr_field;
  logic [5:0]        last_idx;
  logic              data_hs;
  logic              is_last;

  logic unused_cfg;
  assign unused_cfg = ^{num_pkts[31:6], cmd[15:2]};

  always_comb begin
    beats_cfg  = (num_pkts[5:0] == 6'd0) ? 6'd32 : num_pkts[5:0];
    // 8-bit arithmetic: 32 beats wraps 256-1 to 8'hFF.
    size_cfg   = {beats_cfg[4:0], 3'b000} - 8'd1;
    // A clear in the same cycle as the header latch must be reflected in it.
    tid_eff    = cmd[1] ? 8'd0 : tid;
    off_eff    = cmd[1] ? '0 : addr_off;
    hdr_addr   = base_addr + off_eff;
    addr_field = 34'(hdr_addr);
    last_idx   = beats - 6'd1;
    data_hs    = (state == StData) && S_AXIS_TVALID && M_AXIS_TREADY;
    is_last    = (beat_cnt == last_idx) || S_AXIS_TLAST;
  end

  // The header and TUSER are captured when the packet starts, so they stay
  // stable under backpressure even if cmd or the counters change meanwhile.
  always_ff @(posedge AXIS_ACLK) begin
    if (AXIS_ARESET) begin
      state     <= StIdle;
      beats     <= '0;
      beat_cnt  <= '0;
      tid       <= '0;
      pkt_cnt   <= '0;
      addr_off  <= '0;
      short_err <= 1'b0;
      hdr       <= '0;
      tuser     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (cmd[0] && S_AXIS_TVALID) begin
            state <= StHdr;
            beats <= beats_cfg;
            hdr   <= {tid_eff, 4'h6, 4'h0, 1'b0, 2'b01, 1'b0, size_cfg, 2'b00, addr_field};
            tuser <= {src_id, cmd[31:16]};
          end
        end
        StHdr: begin
          if (M_AXIS_TREADY) begin
            state    <= StData;
            beat_cnt <= '0;
          end
        end
        StData: begin
          if (data_hs) begin
            beat_cnt <= beat_cnt + 6'd1;
            if (is_last) begin
              state   <= StIdle;
              tid     <= tid + 8'd1;
              pkt_cnt <= pkt_cnt + 16'd1;
              if (S_AXIS_TLAST) begin
                addr_off <= '0;
                if (beat_cnt < last_idx) begin
                  short_err <= 1'b1;
                end
              end else begin
                addr_off <= addr_off + (ADDR_W'(beats) << 3);
              end
            end
          end
        end
        default: state <= StIdle;
      endcase
      // Clear overrides any end-of-packet update in the same cycle.
      if (cmd[1]) begin
        tid       <= '0;
        pkt_cnt   <= '0;
        addr_off  <= '0;
        short_err <= 1'b0;
      end
    end
  end

  always_comb begin
    M_AXIS_TDATA  = '0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    S_AXIS_TREADY = 1'b0;
    unique case (state)
      StHdr: begin
        M_AXIS_TDATA  = hdr;
        M_AXIS_TVALID = 1'b1;
      end
      StData: begin
        M_AXIS_TDATA  = S_AXIS_TDATA;
        M_AXIS_TVALID = S_AXIS_TVALID;
        M_AXIS_TLAST  = is_last;
        S_AXIS_TREADY = M_AXIS_TREADY;
      end
      default: ;
    endcase
  end

  assign M_AXIS_TUSER = tuser;
  assign status       = {14'd0, (state != StIdle), short_err, pkt_cnt};

endmodule
